awg_sweep_ctrl: RTL and testbench
=================================

Name: awg_sweep_ctrl

Overview:
- Sequencer that drives the freq/amp/phase/en control inputs of the triangle/DDS waveform generator.
- Runs programmable frequency sweeps (single, repeat, up-down) with a per-step dwell time.
- Sits between the host configuration registers and the generator.
- Owns parameter validity: generator amp is a divisor and must never be 0.

Parameters:
FREQ_W, 12, width of frequency tuning word (generator address step)
AMP_W, 4, width of amplitude divisor
PH_W, 8, width of channel-B phase offset
DWELL_W, 16, width of dwell counter (cycles per step minus 1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cfg_wr  in  1  write strobe for all cfg_* fields
cfg_f_start  in  FREQ_W  sweep start tuning word
cfg_f_stop  in  FREQ_W  sweep stop tuning word
cfg_f_step  in  FREQ_W  tuning-word increment per step
cfg_dwell  in  DWELL_W  hold cycles per step minus 1
cfg_mode  in  2  0=single, 1=repeat, 2=updown, 3=reserved (treated as single)
cfg_amp  in  AMP_W  amplitude divisor
cfg_phase  in  PH_W  phase offset
cfg_ack  out  1  one-cycle pulse: config accepted
cfg_err  out  1  one-cycle pulse: cfg_wr rejected (busy)
start  in  1  begin sweep (level or pulse; sampled only in IDLE)
stop  in  1  abort sweep
busy  out  1  high in RUN_UP/RUN_DOWN
done  out  1  one-cycle pulse at single-sweep completion
gen_en  out  1  to generator en
gen_freq  out  FREQ_W  to generator freq
gen_amp  out  AMP_W  to generator amp
gen_phase  out  PH_W  to generator phase

Behaviour:
- All outputs registered. Reset values: gen_en=0, gen_freq=0, gen_amp=1, gen_phase=0, busy=0, done=0, cfg_ack=0, cfg_err=0, state=IDLE, shadow config = start 0, stop 0, step 0, dwell 0, mode 0, amp 1, phase 0.
- Reset mid-sweep returns to the reset values on the next edge; no done pulse.
- Config:
  - cfg_wr in IDLE latches all fields into shadow registers; cfg_ack pulses next cycle.
  - cfg_wr while busy is ignored; cfg_err pulses next cycle; shadow registers are unchanged.
  - cfg_amp=0 is latched as 1.
- States: IDLE, RUN_UP, RUN_DOWN.
- IDLE -> RUN_UP on start && !stop.
  - Next cycle: gen_en=1, busy=1, gen_freq=f_start, gen_amp/gen_phase=shadow.
  - Dwell counter loaded with dwell.
  - cfg_wr and start in the same cycle are both accepted; the sweep uses the new values (forwarded).
- Step timing: gen_freq holds for dwell+1 cycles, then updates. dwell=0 means a new value every cycle.
- RUN_UP step: nxt = gen_freq + step, computed FREQ_W+1 wide; if nxt >= f_stop, gen_freq = f_stop (clamp, never wraps).
- On expiry of the dwell at f_stop in RUN_UP:
  - single: IDLE; gen_en=0, busy=0, done=1 for one cycle; gen_freq holds f_stop.
  - repeat: gen_freq=f_start, stay RUN_UP.
  - updown: go to RUN_DOWN. Down step: nxt = gen_freq - step, clamped to f_start (no underflow). Dwell expiry at f_start -> RUN_UP.
- Degenerate configs (step=0, or f_start >= f_stop): gen_freq stays at f_start indefinitely. No done; only stop exits.
- stop (any run state, priority over everything except rst) -> IDLE next cycle: gen_en=0, busy=0, no done. stop in IDLE has no effect.
- gen_amp/gen_phase change only at sweep start.

Decomposition:
- Package awg_pkg holds:
  - mode encodings MODE_SINGLE/MODE_REPEAT/MODE_UPDOWN
  - state enum
  - default widths FREQ_W/AMP_W/PH_W/DWELL_W
  - AMP_MIN=1
- One sub-module, awg_dwell_timer: a load/decrement counter with an expire flag. It is reused by future burst/gate controllers.

Test Plan:
- Single: start=100, stop=130, step=10, dwell=2, start -> gen_freq 100,110,120,130, each held 3 cycles. gen_en high 12 cycles, then done pulse and gen_en=0.
- Clamp/updown: start=0, stop=25, step=10, dwell=0, mode=2 -> gen_freq 0,10,20,25,15,5,0,10,... until stop. No wrap past 4095 with start=4090, stop=4095, step=10.
- Repeat + stop: start=50, stop=70, step=10, dwell=1, mode=1 -> 50,50,60,60,70,70,50,... Assert stop mid-step -> next cycle gen_en=0, busy=0, no done.
- Config handshake: cfg_wr during busy -> cfg_err pulse, values unchanged on next sweep. cfg_wr amp=0 in IDLE -> cfg_ack pulse, gen_amp=1 at start.
- Degenerate: step=0 or start=200, stop=100 -> gen_freq constant 200 for 1000 cycles, done never asserted.
- Reset mid-sweep: rst high during RUN_DOWN -> all outputs at reset values next edge. cfg_wr+start same cycle in IDLE -> first gen_freq equals the new cfg_f_start.

Source files
------------

// File: rtl/awg_pkg.sv
// Shared definitions for the AWG sweep controller family.
// Holds the default widths, the sweep mode encodings and the controller state type.
// Contains no logic, so it has no latency and no backpressure.
package awg_pkg;

    // Default widths of the generator control words
    localparam int DEF_FREQ_W  = 12;
    localparam int DEF_AMP_W   = 4;
    localparam int DEF_PH_W    = 8;
    localparam int DEF_DWELL_W = 16;

    // Sweep modes; encoding 3 is reserved and behaves like single
    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_REPEAT = 2'd1;
    localparam logic [1:0] MODE_UPDOWN = 2'd2;

    // Amplitude is a divisor in the generator and must never be zero
    localparam int AMP_MIN = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } state_t;

endpackage

// File: rtl/awg_dwell_timer.sv
// Load/decrement dwell counter with an expire flag.
// Latency: a load is visible on the next edge; expired_o is high while the count is zero.
// Backpressure: none; a load always wins over the decrement.
module awg_dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload on request, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/awg_sweep_ctrl.sv
// Frequency sweep sequencer driving the freq/amp/phase/en inputs of the waveform generator.
// Latency: start/cfg_wr/stop take effect on the next edge; every output is registered.
// Backpressure: cfg_wr while a sweep runs is dropped and flagged with a cfg_err pulse.
module awg_sweep_ctrl
    import awg_pkg::*;
#(
    parameter int FREQ_W  = DEF_FREQ_W,
    parameter int AMP_W   = DEF_AMP_W,
    parameter int PH_W    = DEF_PH_W,
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_wr,
    input  logic [FREQ_W-1:0]  cfg_f_start,
    input  logic [FREQ_W-1:0]  cfg_f_stop,
    input  logic [FREQ_W-1:0]  cfg_f_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [1:0]         cfg_mode,
    input  logic [AMP_W-1:0]   cfg_amp,
    input  logic [PH_W-1:0]    cfg_phase,
    output logic               cfg_ack,
    output logic               cfg_err,
    input  logic               start,
    input  logic               stop,
    output logic               busy,
    output logic               done,
    output logic               gen_en,
    output logic [FREQ_W-1:0]  gen_freq,
    output logic [AMP_W-1:0]   gen_amp,
    output logic [PH_W-1:0]    gen_phase
);

    localparam logic [AMP_W-1:0] AMP_RST = AMP_W'(AMP_MIN);

    state_t               state_q;
    logic [FREQ_W-1:0]    f_start_q, f_stop_q, f_step_q;
    logic [DWELL_W-1:0]   dwell_q;
    logic [1:0]           mode_q;
    logic [AMP_W-1:0]     amp_q;
    logic [PH_W-1:0]      phase_q;
    logic                 cfg_ack_q, cfg_err_q, busy_q, done_q, gen_en_q;
    logic [FREQ_W-1:0]    gen_freq_q;
    logic [AMP_W-1:0]     gen_amp_q;
    logic [PH_W-1:0]      gen_phase_q;

    logic                 idle, cfg_take, launch, tmr_load, expired, degen;
    logic [AMP_W-1:0]     cfg_amp_safe;
    logic [FREQ_W-1:0]    eff_start;
    logic [AMP_W-1:0]     eff_amp;
    logic [PH_W-1:0]      eff_phase;
    logic [DWELL_W-1:0]   eff_dwell, tmr_val;
    logic [FREQ_W:0]      up_sum, dn_diff;
    logic [FREQ_W-1:0]    up_nxt, dn_nxt;

    // Config forwarding, launch/reload decisions and clamped step values
    always_comb begin
        idle         = (state_q == IDLE);
        cfg_take     = cfg_wr && idle;
        launch       = idle && start && !stop;
        cfg_amp_safe = (cfg_amp == '0) ? AMP_RST : cfg_amp;
        // A write in the launch cycle is forwarded so the sweep sees the new values
        eff_start    = cfg_take ? cfg_f_start  : f_start_q;
        eff_amp      = cfg_take ? cfg_amp_safe : amp_q;
        eff_phase    = cfg_take ? cfg_phase    : phase_q;
        eff_dwell    = cfg_take ? cfg_dwell    : dwell_q;
        tmr_load     = launch || (!idle && !stop && expired);
        tmr_val      = idle ? eff_dwell : dwell_q;
        // Zero step or an empty/inverted range parks the sweep at f_start
        degen        = (f_step_q == '0) || (f_start_q >= f_stop_q);
        // One extra bit so the sum cannot wrap and the difference exposes underflow
        up_sum       = {1'b0, gen_freq_q} + {1'b0, f_step_q};
        dn_diff      = {1'b0, gen_freq_q} - {1'b0, f_step_q};
        up_nxt       = (up_sum >= {1'b0, f_stop_q}) ? f_stop_q : up_sum[FREQ_W-1:0];
        dn_nxt       = (dn_diff[FREQ_W] || (dn_diff[FREQ_W-1:0] <= f_start_q))
                       ? f_start_q : dn_diff[FREQ_W-1:0];
    end

    awg_dwell_timer #(.W(DWELL_W)) u_dwell (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (expired)
    );

    // Sweep FSM, shadow config and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            f_start_q   <= '0;
            f_stop_q    <= '0;
            f_step_q    <= '0;
            dwell_q     <= '0;
            mode_q      <= MODE_SINGLE;
            amp_q       <= AMP_RST;
            phase_q     <= '0;
            cfg_ack_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            gen_en_q    <= 1'b0;
            gen_freq_q  <= '0;
            gen_amp_q   <= AMP_RST;
            gen_phase_q <= '0;
        end else begin
            cfg_ack_q <= cfg_take;
            cfg_err_q <= cfg_wr && !idle;
            done_q    <= 1'b0;
            if (cfg_take) begin
                f_start_q <= cfg_f_start;
                f_stop_q  <= cfg_f_stop;
                f_step_q  <= cfg_f_step;
                dwell_q   <= cfg_dwell;
                mode_q    <= cfg_mode;
                amp_q     <= cfg_amp_safe;
                phase_q   <= cfg_phase;
            end
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        state_q     <= RUN_UP;
                        busy_q      <= 1'b1;
                        gen_en_q    <= 1'b1;
                        gen_freq_q  <= eff_start;
                        gen_amp_q   <= eff_amp;
                        gen_phase_q <= eff_phase;
                    end
                end
                RUN_UP: begin
                    if (stop) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        gen_en_q <= 1'b0;
                    end else if (expired && !degen) begin
                        if (gen_freq_q == f_stop_q) begin
                            case (mode_q)
                                MODE_REPEAT: gen_freq_q <= f_start_q;
                                MODE_UPDOWN: begin
                                    state_q    <= RUN_DOWN;
                                    gen_freq_q <= dn_nxt;
                                end
                                default: begin
                                    state_q  <= IDLE;
                                    busy_q   <= 1'b0;
                                    gen_en_q <= 1'b0;
                                    done_q   <= 1'b1;
                                end
                            endcase
                        end else begin
                            gen_freq_q <= up_nxt;
                        end
                    end
                end
                RUN_DOWN: begin
                    if (stop) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        gen_en_q <= 1'b0;
                    end else if (expired) begin
                        if (gen_freq_q == f_start_q) begin
                            state_q    <= RUN_UP;
                            gen_freq_q <= up_nxt;
                        end else begin
                            gen_freq_q <= dn_nxt;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cfg_ack   = cfg_ack_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign gen_en    = gen_en_q;
    assign gen_freq  = gen_freq_q;
    assign gen_amp   = gen_amp_q;
    assign gen_phase = gen_phase_q;

endmodule

// File: tb/tb_awg_sweep_ctrl.sv
// Directed bench for awg_sweep_ctrl: inputs driven after the falling edge, outputs checked at the falling edge.
module tb_awg_sweep_ctrl;
    import awg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr;
    logic [11:0] cfg_f_start, cfg_f_stop, cfg_f_step;
    logic [15:0] cfg_dwell;
    logic [1:0]  cfg_mode;
    logic [3:0]  cfg_amp;
    logic [7:0]  cfg_phase;
    logic        cfg_ack, cfg_err, start, stop, busy, done, gen_en;
    logic [11:0] gen_freq;
    logic [3:0]  gen_amp;
    logic [7:0]  gen_phase;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    awg_sweep_ctrl dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr),
        .cfg_f_start(cfg_f_start), .cfg_f_stop(cfg_f_stop), .cfg_f_step(cfg_f_step),
        .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode), .cfg_amp(cfg_amp), .cfg_phase(cfg_phase),
        .cfg_ack(cfg_ack), .cfg_err(cfg_err), .start(start), .stop(stop),
        .busy(busy), .done(done), .gen_en(gen_en), .gen_freq(gen_freq),
        .gen_amp(gen_amp), .gen_phase(gen_phase)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic set_cfg(input int fs, input int fe, input int st, input int dw,
                           input int md, input int am, input int ph);
        cfg_f_start = 12'(fs); cfg_f_stop = 12'(fe); cfg_f_step = 12'(st);
        cfg_dwell = 16'(dw); cfg_mode = 2'(md); cfg_amp = 4'(am); cfg_phase = 8'(ph);
    endtask

    task automatic write_cfg();
        cfg_wr = 1'b1;
        tick();
        cfg_wr = 1'b0;
        chk("cfg_ack", cfg_ack, 1);
        chk("cfg_err_idle", cfg_err, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_en", gen_en, 0);
        chk("stop_busy", busy, 0);
        chk("stop_done", done, 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_en"},    gen_en, 0);
        chk({tag, "_freq"},  gen_freq, 0);
        chk({tag, "_amp"},   gen_amp, 1);
        chk({tag, "_phase"}, gen_phase, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_ack"},   cfg_ack, 0);
        chk({tag, "_err"},   cfg_err, 0);
    endtask

    int exp_single [12] = '{100,100,100,110,110,110,120,120,120,130,130,130};
    int exp_updown [11] = '{0,10,20,25,15,5,0,10,20,25,15};
    int exp_repeat [9]  = '{50,50,60,60,70,70,50,50,60};

    initial begin
        rst = 1'b1; cfg_wr = 1'b0; start = 1'b0; stop = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk_reset_vals("rst");
        rst = 1'b0;
        tick();

        // Single sweep 100..130 step 10, each value held 3 cycles, then done
        set_cfg(100, 130, 10, 2, 0, 5, 8'h33);
        write_cfg();
        tick();
        chk("ack_one_cycle", cfg_ack, 0);
        do_start();
        chk("single_amp", gen_amp, 5);
        chk("single_phase", gen_phase, 8'h33);
        for (int i = 0; i < 12; i++) begin
            chk("single_freq", gen_freq, exp_single[i]);
            chk("single_en", gen_en, 1);
            chk("single_busy", busy, 1);
            chk("single_nodone", done, 0);
            tick();
        end
        chk("single_done", done, 1);
        chk("single_en_off", gen_en, 0);
        chk("single_busy_off", busy, 0);
        chk("single_hold", gen_freq, 130);
        tick();
        chk("single_done_pulse", done, 0);

        // Up-down with clamping; cfg_wr and start together use the new f_start
        set_cfg(0, 25, 10, 0, 2, 3, 8'h11);
        cfg_wr = 1'b1; start = 1'b1;
        tick();
        cfg_wr = 1'b0; start = 1'b0;
        chk("fwd_ack", cfg_ack, 1);
        chk("fwd_amp", gen_amp, 3);
        for (int i = 0; i < 11; i++) begin
            chk("updown_freq", gen_freq, exp_updown[i]);
            chk("updown_nodone", done, 0);
            tick();
        end
        // Now in RUN_DOWN at 5; reset returns every output to its reset value
        chk("updown_pre_rst", gen_freq, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("midrst");
        tick();

        // Top-of-range clamp, no wrap past 4095
        set_cfg(4090, 4095, 10, 0, 0, 1, 0);
        write_cfg();
        do_start();
        chk("wrap_first", gen_freq, 4090);
        tick();
        chk("wrap_clamp", gen_freq, 4095);
        tick();
        chk("wrap_done", done, 1);
        chk("wrap_hold", gen_freq, 4095);
        tick();

        // Repeat with amp=0 latched as 1, rejected cfg_wr while busy, stop mid-step
        set_cfg(50, 70, 10, 1, 1, 0, 8'h44);
        write_cfg();
        do_start();
        chk("amp0_as_1", gen_amp, 1);
        for (int i = 0; i < 9; i++) begin
            chk("repeat_freq", gen_freq, exp_repeat[i]);
            chk("repeat_nodone", done, 0);
            if (i == 2) begin
                set_cfg(999, 3000, 7, 5, 0, 7, 8'h99);
                cfg_wr = 1'b1;
            end else begin
                cfg_wr = 1'b0;
            end
            tick();
            if (i == 2) begin
                chk("busy_cfg_err", cfg_err, 1);
                chk("busy_cfg_noack", cfg_ack, 0);
            end
        end
        cfg_wr = 1'b0;
        chk("repeat_mid", gen_freq, 60);
        do_stop();
        tick();
        chk("stop_no_late_done", done, 0);
        // Next sweep still uses the config accepted before the rejected write
        do_start();
        chk("unchanged_freq", gen_freq, 50);
        chk("unchanged_amp", gen_amp, 1);
        chk("unchanged_phase", gen_phase, 8'h44);
        do_stop();
        // Stop in IDLE does nothing; start together with stop does not launch
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        chk("start_stop_idle_busy", busy, 0);
        chk("start_stop_idle_en", gen_en, 0);

        // Degenerate: inverted range parks at f_start
        set_cfg(200, 100, 10, 0, 0, 2, 0);
        write_cfg();
        do_start();
        for (int i = 0; i < 1000; i++) begin
            chk("degen_range_freq", gen_freq, 200);
            chk("degen_range_done", done, 0);
            tick();
        end
        chk("degen_range_en", gen_en, 1);
        do_stop();

        // Degenerate: zero step parks at f_start
        set_cfg(200, 300, 0, 0, 0, 2, 0);
        write_cfg();
        do_start();
        for (int i = 0; i < 50; i++) begin
            chk("degen_step_freq", gen_freq, 200);
            chk("degen_step_done", done, 0);
            tick();
        end
        do_stop();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
